wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges NSRC result channels onto one registered register-file write port.
// Fixed-priority by default; define WB_RR_ARB_EN for round-robin arbitration.
module wb_arbiter #(
  parameter int NSRC = 4,
  parameter int DW   = 32,
  parameter int RW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NSRC-1:0]    src_valid,
  output logic [NSRC-1:0]    src_ready,
  input  logic [NSRC*RW-1:0] src_regf,
  input  logic [NSRC*DW-1:0] src_data,
  output logic               rd_we,
  output logic [RW-1:0]      rd_regf,
  output logic [DW-1:0]      rd_data,
  output logic               wb_busy
);

  localparam int IW = $clog2(NSRC);

  logic [NSRC-1:0] live;
  logic [NSRC-1:0] null_req;
  logic [NSRC-1:0] gnt_oh;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            arb_en;
  logic            gnt_vld;

  logic            rd_we_q,   rd_we_d;
  logic [RW-1:0]   rd_regf_q, rd_regf_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;

  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no path can infer a latch.
    live     = '0;
    null_req = '0;
    for (int i = 0; i < NSRC; i++) begin
      live[i]     = src_valid[i] && (src_regf[i*RW +: RW] != '0);
      null_req[i] = src_valid[i] && (src_regf[i*RW +: RW] == '0);
    end
  end

`ifdef WB_RR_ARB_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand_idx;

  // Search upward from the pointer, wrapping to channel 0.
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand_idx = IW'((int'(ptr_q) + k) % NSRC);
      if (!gnt_any && live[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == IW'(NSRC - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`else
  // Lowest live channel index wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (live[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    arb_en  = !rst && !flush;
    gnt_vld = arb_en && gnt_any;
    gnt_oh  = '0;
    gnt_oh[gnt_idx] = gnt_vld;

    if (rst) begin
      src_ready = '0;
    end else if (flush) begin
      src_ready = src_valid;
    end else begin
      src_ready = null_req | gnt_oh;
    end

    // Two or more live requests means at least one is left waiting.
    wb_busy = arb_en && ((live & (live - NSRC'(1))) != '0);

    rd_we_d   = gnt_vld;
    rd_regf_d = '0;
    rd_data_d = rd_data_q;
    if (gnt_vld) begin
      rd_regf_d = src_regf[gnt_idx*RW +: RW];
      rd_data_d = src_data[gnt_idx*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rd_we_q   <= 1'b0;
      rd_regf_q <= '0;
      rd_data_q <= '0;
`ifdef WB_RR_ARB_EN
      ptr_q     <= '0;
`endif
    end else begin
      rd_we_q   <= rd_we_d;
      rd_regf_q <= rd_regf_d;
      rd_data_q <= rd_data_d;
`ifdef WB_RR_ARB_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign rd_we   = rd_we_q;
  assign rd_regf = rd_regf_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a
// queue-based scoreboard; the reference model tracks held requests per channel.
module tb_wb_arbiter;

  localparam int NSRC = 4;
  localparam int DW   = 32;
  localparam int RW   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [NSRC-1:0]    src_valid;
  logic [NSRC-1:0]    src_ready;
  logic [NSRC*RW-1:0] src_regf;
  logic [NSRC*DW-1:0] src_data;
  logic               rd_we;
  logic [RW-1:0]      rd_regf;
  logic [DW-1:0]      rd_data;
  logic               wb_busy;

  always #5 clk = ~clk;

  wb_arbiter #(.NSRC(NSRC), .DW(DW), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_regf  (src_regf),
    .src_data  (src_data),
    .rd_we     (rd_we),
    .rd_regf   (rd_regf),
    .rd_data   (rd_data),
    .wb_busy   (wb_busy)
  );

  typedef struct packed {
    logic [RW-1:0] regf;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_hold = '0;
  bit            mon_en   = 1'b0;

  // Requests each source is currently holding.
  bit            pv   [NSRC];
  logic [RW-1:0] preg [NSRC];
  logic [DW-1:0] pdat [NSRC];
  int            rr_p = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int ch, input int regf, input logic [DW-1:0] d);
    pv[ch]   = 1'b1;
    preg[ch] = RW'(regf);
    pdat[ch] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NSRC; i++) begin
      pv[i]   = 1'b0;
      preg[i] = '0;
      pdat[i] = '0;
    end
  endtask

  // One cycle: drive held requests at negedge, predict responses, retire accepted requests.
  task automatic step(input bit r, input bit f);
    logic [NSRC-1:0] exp_rdy;
    int              g;
    int              nlive;
    int              c;
    @(negedge clk);
    rst   = r;
    flush = f;
    for (int i = 0; i < NSRC; i++) begin
      src_valid[i]          = pv[i];
      src_regf[i*RW +: RW]  = preg[i];
      src_data[i*DW +: DW]  = pdat[i];
    end
    #1;
    exp_rdy = '0;
    g       = -1;
    nlive   = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (pv[i] && preg[i] != 0) nlive++;
    end
    if (r) begin
      rr_p     = 0;
      exp_hold = '0;
    end else if (f) begin
      for (int i = 0; i < NSRC; i++) exp_rdy[i] = pv[i];
    end else begin
`ifdef WB_RR_ARB_EN
      for (int k = 0; k < NSRC; k++) begin
        c = (rr_p + k) % NSRC;
        if (g < 0 && pv[c] && preg[c] != 0) g = c;
      end
`else
      for (int i = 0; i < NSRC; i++) begin
        if (g < 0 && pv[i] && preg[i] != 0) g = i;
      end
`endif
      for (int i = 0; i < NSRC; i++) begin
        if (pv[i] && preg[i] == 0) exp_rdy[i] = 1'b1;
      end
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_q.push_back('{regf: preg[g], data: pdat[g]});
        exp_hold = pdat[g];
        rr_p     = (g + 1) % NSRC;
      end
    end
    check("src_ready", 64'(src_ready), 64'(exp_rdy));
    check("wb_busy", 64'(wb_busy), 64'(!r && !f && nlive >= 2));
    for (int i = 0; i < NSRC; i++) begin
      if (exp_rdy[i]) pv[i] = 1'b0;
    end
  endtask

  // Monitor: pops an expected write whenever the DUT presents rd_we.
  initial begin
    wr_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (rd_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got regf=%0d data=0x%0h expected no write", rd_regf, rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_regf", 64'(rd_regf), 64'(e.regf));
          check("rd_data", 64'(rd_data), 64'(e.data));
        end
      end else begin
        check("missed_write", 64'(exp_q.size()), 64'd0);
        check("idle_rd_we", 64'(rd_we), 64'd0);
        check("idle_rd_regf", 64'(rd_regf), 64'd0);
        check("idle_rd_data", 64'(rd_data), 64'(exp_hold));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_regf  = '0;
    src_data  = '0;
    clear_all();

    step(1, 0);
    step(1, 0);
    mon_en = 1'b1;

    // Single request on ch2.
    load(2, 7, 32'h1234);
    step(0, 0);
    step(0, 0);

    // Two-way contention on ch0/ch1.
    load(0, 3, 32'hA0A0_0003);
    load(1, 4, 32'hB1B1_0004);
    step(0, 0);
    step(0, 0);
    step(0, 0);

    // Null on ch0 alongside live ch3.
    load(0, 0, 32'hDEAD_0000);
    load(3, 9, 32'h0000_0009);
    step(0, 0);
    step(0, 0);

    // Flush discards live ch1/ch2 without a write.
    load(1, 5, 32'h1111_1111);
    load(2, 6, 32'h2222_2222);
    step(0, 1);
    step(0, 0);

    // All four held; granted channel re-presents immediately.
    for (int i = 0; i < NSRC; i++) load(i, i + 1, $urandom);
    for (int n = 0; n < 6; n++) begin
      step(0, 0);
      for (int i = 0; i < NSRC; i++) begin
        if (!pv[i]) load(i, i + 1, $urandom);
      end
    end
    clear_all();
    step(0, 0);

    // Reset while ch1 would be granted; ch1 keeps holding and is written after reset.
    load(0, 2, 32'h0BAD_0002);
    step(0, 0);
    load(1, 12, 32'hC0DE_000C);
    step(1, 0);
    step(0, 0);
    step(0, 0);

    // Randomized traffic with occasional flush/reset; small regf range forces collisions.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 45)
          load(i, int'($urandom_range(0, 7)), $urandom);
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0);
    end

    // Drain: with no new traffic every held request is accepted within NSRC cycles.
    for (int n = 0; n < NSRC + 3; n++) step(0, 0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
